// File: rtl/seg_disp_arbiter.sv
// seg_disp_arbiter
// Round-robin arbiter that shares one 8-digit seven-segment display between
// N_REQ requesters. A grant is held for at least HOLD_CYCLES so that a full
// display scan completes before the display can change owner. On the edge where
// the hold expires, the OPEN rules apply immediately. A contended grant therefore
// lasts exactly HOLD_CYCLES cycles.
module seg_disp_arbiter #(
    parameter int N_REQ       = 4,
    parameter int HOLD_CYCLES = 32008,
    parameter int HOLD_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_REQ-1:0]      req,
    input  logic [32*N_REQ-1:0]   req_data,
    output logic [N_REQ-1:0]      gnt,
    output logic [31:0]           disp_data,
    output logic                  owner_chg
);

    localparam int                IDX_W     = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [IDX_W-1:0]  LAST_RST  = IDX_W'(N_REQ - 1);

    typedef enum logic [1:0] {
        IDLE,
        OWN,
        OPEN
    } state_t;

    state_t             state;
    logic [IDX_W-1:0]   last;       // current owner, or most recent one when idle
    logic [HOLD_W-1:0]  hold_cnt;

    logic [IDX_W-1:0]   win_idx;
    logic [IDX_W-1:0]   cand_idx;
    logic               win_found;
    logic [N_REQ-1:0]   win_mask;
    logic [N_REQ-1:0]   owner_mask;
    logic               owner_req;
    logic               others_req;
    logic               hold_done;
    logic               expired;
    logic               do_load;
    logic               go_idle;
    logic [31:0]        owner_word;
    logic [31:0]        win_word;

    // Round-robin search starting just after the last owner; the owner itself is tried last.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        win_found = 1'b0;
        win_idx   = last;
        cand_idx  = last;
        for (int k = 1; k <= N_REQ; k++) begin
            cand_idx = IDX_W'((int'(last) + k) % N_REQ);
            if (!win_found && req[cand_idx]) begin
                win_found = 1'b1;
                win_idx   = cand_idx;
            end
        end
    end

    // Decode owner and winner, and decide between grant load, release to idle, or hold.
    always_comb begin
        owner_mask       = '0;
        owner_mask[last] = 1'b1;
        win_mask         = '0;
        win_mask[win_idx] = 1'b1;
        owner_req  = req[last];
        others_req = |(req & ~owner_mask);
        // Only the owner's lane is read, so X on other lanes never reaches disp_data.
        owner_word = req_data[int'(last) * 32 +: 32];
        win_word   = req_data[int'(win_idx) * 32 +: 32];
        hold_done  = (hold_cnt == HOLD_LAST);
        expired    = (state == OPEN) || ((state == OWN) && hold_done);
        do_load    = ((state == IDLE) && win_found) || (expired && others_req);
        go_idle    = expired && (req == '0);
    end

    // Arbitration state, grant and display registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            gnt       <= '0;
            disp_data <= '0;
            owner_chg <= 1'b0;
            hold_cnt  <= '0;
            last      <= LAST_RST;
        end else begin
            // NOTE: state registers use non-blocking assignments so all updates see pre-edge values.
            owner_chg <= do_load;
            if (do_load) begin
                state     <= OWN;
                gnt       <= win_mask;
                last      <= win_idx;
                disp_data <= win_word;
                hold_cnt  <= '0;
            end else if (go_idle) begin
                state <= IDLE;
                gnt   <= '0;
            end else if (state != IDLE) begin
                if (owner_req) begin
                    disp_data <= owner_word;
                end
                if (hold_done) begin
                    state <= OPEN;
                end else begin
                    hold_cnt <= hold_cnt + HOLD_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_seg_disp_arbiter.sv
// tb_seg_disp_arbiter
// Scoreboard bench for seg_disp_arbiter with N_REQ=4, HOLD_CYCLES=8. A reference
// model tracks the owner and how long it has been shown. After every clock edge it
// queues the expected outputs. A monitor compares them on the falling edge.
module tb_seg_disp_arbiter;

    localparam int N  = 4;
    localparam int H  = 8;
    localparam int HW = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [N-1:0]      req = '0;
    logic [32*N-1:0]   req_data = '0;
    logic [N-1:0]      gnt;
    logic [31:0]       disp_data;
    logic              owner_chg;

    typedef struct {
        logic [N-1:0] gnt;
        logic [31:0]  disp;
        logic         chg;
    } exp_t;

    exp_t exp_q[$];

    int n_checks = 0;
    int n_errors = 0;

    // reference model state
    int          m_owner = -1;   // -1 when nobody owns the display
    int          m_held  = 0;    // cycles the current grant has been visible
    int          m_last  = N - 1;
    logic [31:0] m_disp  = '0;
    logic        m_chg   = 1'b0;

    always #5 clk = ~clk;

    seg_disp_arbiter #(
        .N_REQ       (N),
        .HOLD_CYCLES (H),
        .HOLD_W      (HW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_data  (req_data),
        .gnt       (gnt),
        .disp_data (disp_data),
        .owner_chg (owner_chg)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic logic [31:0] lane(input int i);
        return req_data[32*i +: 32];
    endfunction

    function automatic int rr_pick();
        for (int k = 1; k <= N; k++) begin
            if (req[(m_last + k) % N]) return (m_last + k) % N;
        end
        return -1;
    endfunction

    // One clock edge of the arbitration rules.
    task automatic model_step();
        int w;
        exp_t e;
        if (rst) begin
            m_owner = -1; m_held = 0; m_last = N - 1; m_disp = '0; m_chg = 1'b0;
        end else begin
            w = -1;
            if (m_owner < 0) begin
                if (req != '0) w = rr_pick();
            end else if (m_held >= H) begin
                if ((req & ~(N'(1) << m_owner)) != '0) w = rr_pick();
                else if (req == '0) m_owner = -1;
            end
            if (w >= 0) begin
                m_owner = w; m_last = w; m_held = 1; m_disp = lane(w); m_chg = 1'b1;
            end else begin
                m_chg = 1'b0;
                if (m_owner >= 0) begin
                    m_held++;
                    if (req[m_owner]) m_disp = lane(m_owner);
                end
            end
        end
        e.gnt  = (m_owner < 0) ? '0 : (N'(1) << m_owner);
        e.disp = m_disp;
        e.chg  = m_chg;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    // Requesting lanes get fresh data; idle lanes are driven to X.
    task automatic fill_lanes();
        for (int i = 0; i < N; i++) begin
            req_data[32*i +: 32] = req[i] ? 32'($urandom) : 32'bx;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // Monitor: compare DUT outputs against the queued expectation each falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("sb_gnt", 32'(gnt), 32'(e.gnt));
                check("sb_disp", disp_data, e.disp);
                check("sb_chg", 32'(owner_chg), 32'(e.chg));
                check("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
            end
        end
    end

    initial begin
        int          chg_cnt;
        logic [31:0] keep;

        // 1: reset with all requests high, then release with no requests
        rst = 1'b1; req = '1; fill_lanes();
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_gnt", 32'(gnt), 32'd0);
            check("rst_disp", disp_data, 32'd0);
            check("rst_chg", 32'(owner_chg), 32'd0);
        end
        rst = 1'b0; req = '0; fill_lanes();
        for (int i = 0; i < 3; i++) tick();
        check("post_rst_gnt", 32'(gnt), 32'd0);
        check("post_rst_disp", disp_data, 32'd0);

        // 2: single requester from IDLE, then live update
        req = 4'b0100; fill_lanes(); req_data[64 +: 32] = 32'h12345678;
        tick();
        check("t2_gnt", 32'(gnt), 32'h4);
        check("t2_disp", disp_data, 32'h12345678);
        check("t2_chg", 32'(owner_chg), 32'd1);
        tick();
        check("t2_chg_low", 32'(owner_chg), 32'd0);
        req_data[64 +: 32] = 32'h00000042;
        tick();
        check("t2_live", disp_data, 32'h00000042);
        req = '0; fill_lanes();
        for (int i = 0; i < 10; i++) tick();
        check("t2_idle_gnt", 32'(gnt), 32'd0);
        check("t2_idle_disp", disp_data, 32'h00000042);

        // 3: all requesters, round-robin with 8-cycle grants
        do_reset();
        req = '1;
        for (int n = 0; n < 34; n++) begin
            fill_lanes();
            tick();
            check("t3_gnt", 32'(gnt), 32'(4'b0001 << ((n / 8) % 4)));
            check("t3_chg", 32'(owner_chg), 32'((n % 8) == 0));
        end

        // 4: owner drops mid-hold, display freezes until the hold expires
        do_reset();
        req = 4'b0010; fill_lanes(); req_data[32 +: 32] = 32'hA1;
        tick();
        req_data[32 +: 32] = 32'hA2; tick();
        req_data[32 +: 32] = 32'hA3; tick();
        req = 4'b1000; fill_lanes(); req_data[96 +: 32] = 32'hC3;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t4_hold_gnt", 32'(gnt), 32'h2);
            check("t4_frozen", disp_data, 32'hA3);
        end
        tick();
        check("t4_new_gnt", 32'(gnt), 32'h8);
        check("t4_new_disp", disp_data, 32'hC3);
        check("t4_new_chg", 32'(owner_chg), 32'd1);

        // 5: sole requester keeps the display indefinitely
        do_reset();
        req = 4'b0001;
        chg_cnt = 0;
        keep = '0;
        for (int i = 0; i < 40; i++) begin
            fill_lanes();
            keep = req_data[31:0];
            tick();
            if (owner_chg) chg_cnt++;
            check("t5_gnt", 32'(gnt), 32'h1);
        end
        check("t5_chg_count", 32'(chg_cnt), 32'd1);
        req = '0; fill_lanes();
        tick();
        check("t5_release_gnt", 32'(gnt), 32'd0);
        check("t5_release_disp", disp_data, keep);

        // 6: asynchronous reset mid-grant, then reset priority applies
        do_reset();
        req = 4'b0100; fill_lanes();
        for (int i = 0; i < 3; i++) tick();
        #1 rst = 1'b1;
        #1;
        check("t6_async_gnt", 32'(gnt), 32'd0);
        check("t6_async_disp", disp_data, 32'd0);
        check("t6_async_chg", 32'(owner_chg), 32'd0);
        tick();
        rst = 1'b0; req = 4'b0101; fill_lanes();
        tick();
        check("t6_first_gnt", 32'(gnt), 32'h1);

        // Randomized traffic with occasional resets
        do_reset();
        for (int i = 0; i < 2500; i++) begin
            rst = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 5) == 0) req = N'($urandom);
            fill_lanes();
            tick();
        end
        rst = 1'b0; req = '0; fill_lanes();
        tick();
        #1;
        check("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
